// File: rtl/istasyon_planlayici_if.sv
// Signal bundle between the station planner and its controller/station.
// master drives plan writes, start and station feedback; slave is the planner itself.
interface istasyon_planlayici_if;
  logic       yaz_en;
  logic [4:0] yaz_adres;
  logic [1:0] yaz_veri;
  logic       baslat;
  logic       amorti;
  logic [4:0] amorti_gunu;
  logic [1:0] islem;
  logic       istasyon_sifirla;
  logic [4:0] gun;
  logic       mesgul;
  logic       bitti;
  logic       basarisiz;
  logic [4:0] sonuc_gunu;

  modport master (
    output yaz_en, yaz_adres, yaz_veri, baslat, amorti, amorti_gunu,
    input  islem, istasyon_sifirla, gun, mesgul, bitti, basarisiz, sonuc_gunu
  );

  modport slave (
    input  yaz_en, yaz_adres, yaz_veri, baslat, amorti, amorti_gunu,
    output islem, istasyon_sifirla, gun, mesgul, bitti, basarisiz, sonuc_gunu
  );
endinterface

// File: rtl/istasyon_planlayici.sv
// Replays a stored 32-entry operation plan to a station one day per cycle and reports break-even.
// All outputs registered; a run is station reset (1 cycle), GUN_SAYISI plan days, then up to BEKLEME watch cycles.
module istasyon_planlayici #(
  parameter int         GUN_SAYISI       = 30,
  parameter int         BEKLEME          = 2,
  parameter logic [1:0] VARSAYILAN_ISLEM = 2'd0
) (
  input  logic                  saat,
  input  logic                  reset,
  istasyon_planlayici_if.slave  bus
);

  localparam int         PLAN_DERINLIK = 32;
  localparam logic [4:0] SON_GUN       = 5'(GUN_SAYISI - 1);
  localparam logic [2:0] SON_BEKLEME   = 3'(BEKLEME - 1);

  typedef enum logic [2:0] {
    BOSTA,
    SIFIRLA,
    CALIS,
    BEKLE,
    BITTI
  } durum_t;

  durum_t     durum_q, durum_d;
  logic [1:0] plan_q [PLAN_DERINLIK];
  logic [1:0] plan_d [PLAN_DERINLIK];
  logic [1:0] islem_q, islem_d;
  logic       sifirla_q, sifirla_d;
  logic [4:0] gun_q, gun_d;
  logic       mesgul_q, mesgul_d;
  logic       bitti_q, bitti_d;
  logic       basarisiz_q, basarisiz_d;
  logic [4:0] sonuc_q, sonuc_d;
  logic [2:0] sayac_q, sayac_d;
  logic [4:0] sonraki_gun;
  logic       yazilabilir;

  assign sonraki_gun = gun_q + 5'd1;
  assign yazilabilir = (durum_q == BOSTA) || (durum_q == BITTI);

  always_comb begin
    durum_d     = durum_q;
    plan_d      = plan_q;
    islem_d     = islem_q;
    sifirla_d   = 1'b0;
    gun_d       = gun_q;
    mesgul_d    = mesgul_q;
    bitti_d     = bitti_q;
    basarisiz_d = basarisiz_q;
    sonuc_d     = sonuc_q;
    sayac_d     = sayac_q;

    if (yazilabilir && bus.yaz_en) begin
      plan_d[bus.yaz_adres] = bus.yaz_veri;
    end

    case (durum_q)
      BOSTA, BITTI: begin
        if (bus.baslat) begin
          durum_d     = SIFIRLA;
          sifirla_d   = 1'b1;
          islem_d     = VARSAYILAN_ISLEM;
          gun_d       = 5'd0;
          mesgul_d    = 1'b1;
          bitti_d     = 1'b0;
          basarisiz_d = 1'b0;
          sonuc_d     = 5'd0;
        end
      end

      // plan_q already holds any write made on the start edge, so the run sees it.
      SIFIRLA: begin
        durum_d = CALIS;
        gun_d   = 5'd0;
        islem_d = plan_q[0];
      end

      CALIS: begin
        if (bus.amorti) begin
          durum_d     = BITTI;
          islem_d     = VARSAYILAN_ISLEM;
          mesgul_d    = 1'b0;
          bitti_d     = 1'b1;
          basarisiz_d = 1'b0;
          sonuc_d     = bus.amorti_gunu;
        end else if (gun_q == SON_GUN) begin
          durum_d = BEKLE;
          islem_d = VARSAYILAN_ISLEM;
          sayac_d = 3'd0;
        end else begin
          gun_d   = sonraki_gun;
          islem_d = plan_q[sonraki_gun];
        end
      end

      BEKLE: begin
        if (bus.amorti) begin
          durum_d     = BITTI;
          islem_d     = VARSAYILAN_ISLEM;
          mesgul_d    = 1'b0;
          bitti_d     = 1'b1;
          basarisiz_d = 1'b0;
          sonuc_d     = bus.amorti_gunu;
        end else if (sayac_q == SON_BEKLEME) begin
          durum_d     = BITTI;
          islem_d     = VARSAYILAN_ISLEM;
          mesgul_d    = 1'b0;
          bitti_d     = 1'b1;
          basarisiz_d = 1'b1;
          sonuc_d     = 5'd0;
        end else begin
          sayac_d = sayac_q + 3'd1;
        end
      end

      default: begin
        durum_d  = BOSTA;
        islem_d  = VARSAYILAN_ISLEM;
        mesgul_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum_q     <= BOSTA;
      islem_q     <= VARSAYILAN_ISLEM;
      sifirla_q   <= 1'b0;
      gun_q       <= 5'd0;
      mesgul_q    <= 1'b0;
      bitti_q     <= 1'b0;
      basarisiz_q <= 1'b0;
      sonuc_q     <= 5'd0;
      sayac_q     <= 3'd0;
      for (int i = 0; i < PLAN_DERINLIK; i++) begin
        plan_q[i] <= VARSAYILAN_ISLEM;
      end
    end else begin
      durum_q     <= durum_d;
      islem_q     <= islem_d;
      sifirla_q   <= sifirla_d;
      gun_q       <= gun_d;
      mesgul_q    <= mesgul_d;
      bitti_q     <= bitti_d;
      basarisiz_q <= basarisiz_d;
      sonuc_q     <= sonuc_d;
      sayac_q     <= sayac_d;
      plan_q      <= plan_d;
    end
  end

  assign bus.islem            = islem_q;
  assign bus.istasyon_sifirla = sifirla_q;
  assign bus.gun              = gun_q;
  assign bus.mesgul           = mesgul_q;
  assign bus.bitti            = bitti_q;
  assign bus.basarisiz        = basarisiz_q;
  assign bus.sonuc_gunu       = sonuc_q;

endmodule

// File: tb/tb_istasyon_planlayici.sv
// Bench for istasyon_planlayici: scoreboard of expected daily islem values and run results.
module tb_istasyon_planlayici;
  localparam int         N    = 30;
  localparam int         B    = 2;
  localparam logic [1:0] VARS = 2'd0;

  typedef struct packed {
    logic       basarisiz;
    logic [4:0] sonuc;
    logic [4:0] gun;
  } sonuc_t;

  logic saat  = 1'b0;
  logic reset = 1'b1;

  istasyon_planlayici_if bus ();

  istasyon_planlayici #(
    .GUN_SAYISI       (N),
    .BEKLEME          (B),
    .VARSAYILAN_ISLEM (VARS)
  ) dut (
    .saat  (saat),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 saat = ~saat;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] plan_m [32];
  logic [1:0] day_q [$];
  sonuc_t     res_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_plan(input int n, input logic [1:0] v_even, input logic [1:0] v_odd);
    for (int a = 0; a < n; a++) begin
      @(negedge saat);
      bus.yaz_en    = 1'b1;
      bus.yaz_adres = 5'(a);
      bus.yaz_veri  = (a % 2 == 0) ? v_even : v_odd;
      plan_m[a]     = (a % 2 == 0) ? v_even : v_odd;
    end
    @(negedge saat);
    bus.yaz_en = 1'b0;
  endtask

  // hit: cycle index after SIFIRLA at which amorti is raised (<0 = never).
  task automatic run_plan(input int hit, input logic [4:0] hit_val, input bit wr_mid, input bit wr_start);
    logic [1:0] exp_islem;
    sonuc_t     exp_r;
    sonuc_t     got_r;
    @(negedge saat);
    bus.baslat = 1'b1;
    if (wr_start) begin
      bus.yaz_en    = 1'b1;
      bus.yaz_adres = 5'd0;
      bus.yaz_veri  = 2'd3;
      plan_m[0]     = 2'd3;
    end
    day_q.delete();
    for (int d = 0; d < N; d++) day_q.push_back(plan_m[d]);
    exp_r.basarisiz = (hit < 0);
    exp_r.sonuc     = (hit < 0) ? 5'd0 : hit_val;
    exp_r.gun       = (hit >= 0 && hit < N) ? 5'(hit) : 5'(N - 1);
    res_q.push_back(exp_r);

    @(negedge saat);
    bus.baslat = 1'b0;
    bus.yaz_en = 1'b0;
    n_checks++;
    if ({bus.istasyon_sifirla, bus.mesgul, bus.bitti} !== 3'b110) begin
      n_errors++;
      $display("FAIL sifirla_state: sifirla/mesgul/bitti=%b expected 110", {bus.istasyon_sifirla, bus.mesgul, bus.bitti});
    end
    n_checks++;
    if (bus.islem !== VARS || bus.basarisiz !== 1'b0 || bus.sonuc_gunu !== 5'd0) begin
      n_errors++;
      $display("FAIL sifirla_outputs: islem=%0d basarisiz=%0d sonuc=%0d expected %0d 0 0", bus.islem, bus.basarisiz, bus.sonuc_gunu, VARS);
    end

    for (int c = 0; c < N + B; c++) begin
      @(negedge saat);
      if (c < N) begin
        exp_islem = day_q.pop_front();
        n_checks++;
        if (bus.islem !== exp_islem || bus.gun !== 5'(c)) begin
          n_errors++;
          $display("FAIL calis_day: cycle %0d islem=%0d gun=%0d expected islem=%0d gun=%0d", c, bus.islem, bus.gun, exp_islem, c);
        end
        n_checks++;
        if ({bus.mesgul, bus.istasyon_sifirla, bus.bitti} !== 3'b100) begin
          n_errors++;
          $display("FAIL calis_flags: cycle %0d mesgul/sifirla/bitti=%b expected 100", c, {bus.mesgul, bus.istasyon_sifirla, bus.bitti});
        end
      end else begin
        n_checks++;
        if (bus.islem !== VARS || bus.mesgul !== 1'b1 || bus.bitti !== 1'b0) begin
          n_errors++;
          $display("FAIL bekle: cycle %0d islem=%0d mesgul=%0d bitti=%0d expected %0d 1 0", c, bus.islem, bus.mesgul, bus.bitti, VARS);
        end
      end
      if (wr_mid && c == 3) begin
        bus.yaz_en    = 1'b1;
        bus.yaz_adres = 5'd1;
        bus.yaz_veri  = 2'd3;
      end
      if (wr_mid && c == 4) bus.yaz_en = 1'b0;
      if (c == hit) begin
        bus.amorti      = 1'b1;
        bus.amorti_gunu = hit_val;
        break;
      end
    end
    day_q.delete();

    @(negedge saat);
    bus.amorti = 1'b0;
    exp_r = res_q.pop_front();
    got_r = '{basarisiz: bus.basarisiz, sonuc: bus.sonuc_gunu, gun: bus.gun};
    n_checks++;
    if (bus.bitti !== 1'b1 || bus.mesgul !== 1'b0) begin
      n_errors++;
      $display("FAIL bitti_flags: bitti=%0d mesgul=%0d expected 1 0", bus.bitti, bus.mesgul);
    end
    n_checks++;
    if (got_r !== exp_r) begin
      n_errors++;
      $display("FAIL result: basarisiz=%0d sonuc=%0d gun=%0d expected %0d %0d %0d",
               got_r.basarisiz, got_r.sonuc, got_r.gun, exp_r.basarisiz, exp_r.sonuc, exp_r.gun);
    end
    n_checks++;
    if (bus.islem !== VARS) begin
      n_errors++;
      $display("FAIL bitti_islem: islem=%0d expected %0d", bus.islem, VARS);
    end

    bus.amorti      = 1'b1;
    bus.amorti_gunu = 5'd17;
    @(negedge saat);
    bus.amorti = 1'b0;
    n_checks++;
    if (bus.bitti !== 1'b1 || bus.sonuc_gunu !== exp_r.sonuc || bus.basarisiz !== exp_r.basarisiz) begin
      n_errors++;
      $display("FAIL bitti_hold: bitti=%0d sonuc=%0d basarisiz=%0d expected 1 %0d %0d",
               bus.bitti, bus.sonuc_gunu, bus.basarisiz, exp_r.sonuc, exp_r.basarisiz);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge saat);
    n_checks++;
    if ({bus.islem, bus.istasyon_sifirla, bus.gun, bus.mesgul, bus.bitti, bus.basarisiz, bus.sonuc_gunu} !== {VARS, 14'd0}) begin
      n_errors++;
      $display("FAIL reset_values: islem=%0d sifirla=%0d gun=%0d mesgul=%0d bitti=%0d basarisiz=%0d sonuc=%0d expected all reset",
               bus.islem, bus.istasyon_sifirla, bus.gun, bus.mesgul, bus.bitti, bus.basarisiz, bus.sonuc_gunu);
    end
    reset = 1'b0;
    @(negedge saat);
    n_checks++;
    if (bus.mesgul !== 1'b0 || bus.bitti !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: mesgul=%0d bitti=%0d expected 0 0", bus.mesgul, bus.bitti);
    end
  endtask

  task automatic test_no_breakeven;
    fill_plan(30, 2'd1, 2'd1);
    run_plan(-1, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_breakeven_calis;
    fill_plan(32, 2'd2, 2'd2);
    run_plan(6, 5'd6, 1'b0, 1'b0);
  endtask

  task automatic test_breakeven_bekle;
    fill_plan(32, 2'd1, 2'd1);
    run_plan(N, 5'd30, 1'b0, 1'b0);
  endtask

  task automatic test_alternating;
    fill_plan(32, 2'd2, 2'd1);
    run_plan(-1, 5'd0, 1'b1, 1'b0);
    run_plan(20, 5'd20, 1'b0, 1'b0);
  endtask

  task automatic test_restart_with_write;
    run_plan(4, 5'd4, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    @(negedge saat);
    bus.baslat = 1'b1;
    @(negedge saat);
    bus.baslat = 1'b0;
    repeat (11) @(negedge saat);
    n_checks++;
    if (bus.gun !== 5'd10 || bus.mesgul !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_abort: gun=%0d mesgul=%0d expected 10 1", bus.gun, bus.mesgul);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.islem, bus.istasyon_sifirla, bus.gun, bus.mesgul, bus.bitti, bus.basarisiz, bus.sonuc_gunu} !== {VARS, 14'd0}) begin
      n_errors++;
      $display("FAIL async_reset: islem=%0d gun=%0d mesgul=%0d bitti=%0d basarisiz=%0d sonuc=%0d expected reset values",
               bus.islem, bus.gun, bus.mesgul, bus.bitti, bus.basarisiz, bus.sonuc_gunu);
    end
    for (int a = 0; a < 32; a++) plan_m[a] = VARS;
    @(negedge saat);
    reset = 1'b0;
    bus.amorti      = 1'b1;
    bus.amorti_gunu = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge saat);
      n_checks++;
      if (bus.bitti !== 1'b0 || bus.mesgul !== 1'b0) begin
        n_errors++;
        $display("FAIL bosta_amorti: bitti=%0d mesgul=%0d expected 0 0", bus.bitti, bus.mesgul);
      end
    end
    bus.amorti = 1'b0;
    reset      = 1'b1;
    bus.baslat = 1'b1;
    @(negedge saat);
    reset = 1'b0;
    @(negedge saat);
    bus.baslat = 1'b0;
    n_checks++;
    if (bus.istasyon_sifirla !== 1'b1 || bus.mesgul !== 1'b1) begin
      n_errors++;
      $display("FAIL start_after_release: sifirla=%0d mesgul=%0d expected 1 1", bus.istasyon_sifirla, bus.mesgul);
    end
    @(negedge saat);
    n_checks++;
    if (bus.islem !== plan_m[0] || bus.gun !== 5'd0) begin
      n_errors++;
      $display("FAIL plan_cleared: islem=%0d gun=%0d expected %0d 0", bus.islem, bus.gun, plan_m[0]);
    end
    reset = 1'b1;
    @(negedge saat);
    reset = 1'b0;
  endtask

  initial begin
    bus.yaz_en      = 1'b0;
    bus.yaz_adres   = 5'd0;
    bus.yaz_veri    = 2'd0;
    bus.baslat      = 1'b0;
    bus.amorti      = 1'b0;
    bus.amorti_gunu = 5'd0;
    for (int a = 0; a < 32; a++) plan_m[a] = VARS;

    test_reset();
    test_no_breakeven();
    test_breakeven_calis();
    test_breakeven_bekle();
    test_alternating();
    test_restart_with_write();
    test_reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
